// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with single-step and burst modes
// Optional registered complement output Q_n is enabled by defining SHIFT_REG_UNIV_QN_EN.
module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              AW        = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic             START,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] Q,
`ifdef SHIFT_REG_UNIV_QN_EN
  output logic [WIDTH-1:0] Q_n,
`endif
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             op_is_shift;

  assign op_is_shift = (OP inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});

  // During a burst the latched op is stepped; live OP is ignored.
  always_comb begin
    step_op   = (state_q == S_SHIFT) ? op_q : OP;
    step_q    = q_q;
    step_sout = sout_q;
    case (step_op)
      OP_LOAD: step_q = D;
      OP_SHL: begin
        step_q    = {q_q[WIDTH-2:0], SIN};
        step_sout = q_q[WIDTH-1];
      end
      OP_SHR: begin
        step_q    = {SIN, q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_ROL: begin
        step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_sout = q_q[WIDTH-1];
      end
      OP_ROR: begin
        step_q    = {q_q[0], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_ASR: begin
        step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_CLR:  step_q = RESET_VAL;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = done_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (EN) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            op_d   = OP;
            done_d = 1'b1;
            if (!(op_is_shift && AMT == '0)) begin
              q_d    = step_q;
              sout_d = step_sout;
            end
            if (op_is_shift && AMT > AW'(1)) begin
              state_d = S_SHIFT;
              cnt_d   = AMT - AW'(1);
              done_d  = 1'b0;
            end
          end else begin
            q_d    = step_q;
            sout_d = step_sout;
          end
        end
        S_SHIFT: begin
          q_d    = step_q;
          sout_d = step_sout;
          cnt_d  = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SHIFT_REG_UNIV_QN_EN
  logic [WIDTH-1:0] qn_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qn_q <= ~RESET_VAL;
    end else begin
      qn_q <= ~q_d;
    end
  end

  assign Q_n = qn_q;
`endif

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign BUSY = (state_q == S_SHIFT);
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - scoreboard bench for shift_reg_univ
// Q_n is connected and checked when SHIFT_REG_UNIV_QN_EN is defined.
module tb_shift_reg_univ;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] SHR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] CLR  = 3'b111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [2:0] OP = 3'b000;
  logic [7:0] D = 8'h00;
  logic       SIN = 1'b0;
  logic       START = 1'b0;
  logic [2:0] AMT = 3'd0;
  logic [7:0] Q;
  logic       SOUT, BUSY, DONE;
`ifdef SHIFT_REG_UNIV_QN_EN
  logic [7:0] Q_n;
`endif

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .OP(OP), .D(D), .SIN(SIN),
    .START(START), .AMT(AMT), .Q(Q),
`ifdef SHIFT_REG_UNIV_QN_EN
    .Q_n(Q_n),
`endif
    .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input string fld,
                              input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    end
  endfunction

  // Monitor: one expected snapshot per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "Q", Q, e.q);
`ifdef SHIFT_REG_UNIV_QN_EN
        chk(e.name, "Q_n", Q_n, ~e.q);
`endif
        chk(e.name, "SOUT", {7'd0, SOUT}, {7'd0, e.sout});
        chk(e.name, "BUSY", {7'd0, BUSY}, {7'd0, e.busy});
        chk(e.name, "DONE", {7'd0, DONE}, {7'd0, e.done});
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [2:0] o,
                     input logic [7:0] dd, input logic s, input logic st,
                     input logic [2:0] a, input string nm, input logic [7:0] eq,
                     input logic es, input logic eb, input logic edn);
    @(negedge CLK);
    #1;
    RST = r; EN = e; OP = o; D = dd; SIN = s; START = st; AMT = a;
    exp_q.push_back('{name: nm, q: eq, sout: es, busy: eb, done: edn});
  endtask

  // Lets one burst step happen, then raises RST between edges.
  task automatic rst_mid(input string nm);
    @(negedge CLK);
    #1;
    RST = 1'b0; EN = 1'b1; OP = HOLD; START = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    exp_q.push_back('{name: nm, q: 8'h00, sout: 1'b0, busy: 1'b0, done: 1'b0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //  rst en op    d      sin st amt  name          q      so bu dn
    cyc(1, 1, LOAD, 8'hFF, 0, 0, 3'd0, "reset",      8'h00, 0, 0, 0);
    cyc(0, 1, LOAD, 8'hA5, 0, 0, 3'd0, "load_a5",    8'hA5, 0, 0, 0);
    cyc(0, 1, ROL,  8'h00, 0, 0, 3'd0, "rol",        8'h4B, 1, 0, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "hold",       8'h4B, 1, 0, 0);
    cyc(0, 1, LOAD, 8'h90, 0, 0, 3'd0, "load_90",    8'h90, 1, 0, 0);
    cyc(0, 1, ASR,  8'h00, 0, 1, 3'd3, "asr_s1",     8'hC8, 0, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "asr_s2",     8'hE4, 0, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "asr_s3",     8'hF2, 0, 0, 1);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "asr_after",  8'hF2, 0, 0, 0);
    cyc(0, 1, LOAD, 8'h01, 0, 0, 3'd0, "load_01",    8'h01, 0, 0, 0);
    cyc(0, 1, ROR,  8'h00, 0, 1, 3'd4, "ror_s1",     8'h80, 1, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "ror_s2",     8'h40, 0, 1, 0);
    cyc(0, 0, LOAD, 8'hFF, 1, 1, 3'd1, "ror_stall1", 8'h40, 0, 1, 0);
    cyc(0, 0, CLR,  8'hFF, 1, 0, 3'd1, "ror_stall2", 8'h40, 0, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "ror_s3",     8'h20, 0, 1, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "ror_s4",     8'h10, 0, 0, 1);
    cyc(0, 0, LOAD, 8'hFF, 0, 0, 3'd0, "done_held",  8'h10, 0, 0, 1);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "done_clr",   8'h10, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 1, 3'd0, "amt0",       8'h10, 0, 0, 1);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "amt0_after", 8'h10, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 0, 1, 3'd3, "busy_s1",    8'h20, 0, 1, 0);
    cyc(0, 1, LOAD, 8'hFF, 1, 1, 3'd5, "busy_s2",    8'h41, 0, 1, 0);
    cyc(0, 1, LOAD, 8'hFF, 0, 1, 3'd5, "busy_s3",    8'h82, 0, 0, 1);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "busy_idle1", 8'h82, 0, 0, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "busy_idle2", 8'h82, 0, 0, 0);
    cyc(0, 1, ROL,  8'h00, 0, 1, 3'd5, "rst_s1",     8'h05, 1, 1, 0);
    rst_mid("rst_async");
    cyc(1, 1, HOLD, 8'h00, 0, 0, 3'd0, "rst_held",   8'h00, 0, 0, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "rst_nodone", 8'h00, 0, 0, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "rst_idle",   8'h00, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl1",       8'h01, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl2",       8'h03, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl3",       8'h07, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl4",       8'h0F, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl5",       8'h1F, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl6",       8'h3F, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl7",       8'h7F, 0, 0, 0);
    cyc(0, 1, SHL,  8'h00, 1, 0, 3'd0, "shl8",       8'hFF, 0, 0, 0);
    cyc(0, 1, SHR,  8'h00, 0, 0, 3'd0, "shr",        8'h7F, 1, 0, 0);
    cyc(0, 1, CLR,  8'h00, 0, 0, 3'd0, "clr",        8'h00, 1, 0, 0);
    cyc(0, 1, HOLD, 8'h00, 0, 0, 3'd0, "final",      8'h00, 1, 0, 0);

    @(negedge CLK);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
